// File: rtl/ins_dec.sv
// Instruction decoder: latches the instruction during decode and emits one
// registered one-hot control strobe during execute.
module ins_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       decode,
  input  logic       execute,
  output logic       load,
  output logic       add,
  output logic       sub,
  output logic       bitand,
  output logic       inp,
  output logic       outp,
  output logic       jump,
  output logic       jumpz,
  output logic       jumpnz,
  output logic       jumpc,
  output logic       jumpnc
);

  localparam logic [7:0] OP_NOP = 8'hF0;

  logic [7:0]  op_q;
  logic [10:0] strobe_r;
  logic [7:0]  dec_src_s;
  logic [10:0] strobe_nxt_s;

  // Strobe bit order: load, add, sub, bitand, inp, outp, jump, jumpz, jumpnz, jumpc, jumpnc
  function automatic logic [10:0] decode_op(input logic [7:0] op);
    logic [10:0] s;
    s = 11'd0;
    casez (op)
      8'b0000_????: s = 11'b000_0000_0001;
      8'b0001_????: s = 11'b000_0000_0010;
      8'b0010_????: s = 11'b000_0000_0100;
      8'b0011_????: s = 11'b000_0000_1000;
      8'b0100_????: s = 11'b000_0001_0000;
      8'b0101_????: s = 11'b000_0010_0000;
      8'b1000_????: s = 11'b000_0100_0000;
      8'b1001_00??: s = 11'b000_1000_0000;
      8'b1001_01??: s = 11'b001_0000_0000;
      8'b1001_10??: s = 11'b010_0000_0000;
      8'b1001_11??: s = 11'b100_0000_0000;
      default:      s = 11'd0;
    endcase
    return s;
  endfunction

  // Select decode source: bypass the incoming instruction when decode and execute coincide
  always_comb begin
    dec_src_s    = op_q;
    strobe_nxt_s = 11'd0;
    if (decode) begin
      dec_src_s = ir;
    end else begin
      dec_src_s = op_q;
    end
    if (execute) begin
      strobe_nxt_s = decode_op(dec_src_s);
    end else begin
      strobe_nxt_s = 11'd0;
    end
  end

  // Instruction capture and registered strobe update
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NOP;
      strobe_r <= 11'd0;
    end else begin
      if (decode) begin
        op_q <= ir;
      end else begin
        op_q <= op_q;
      end
      strobe_r <= strobe_nxt_s;
    end
  end

  assign load   = strobe_r[0];
  assign add    = strobe_r[1];
  assign sub    = strobe_r[2];
  assign bitand = strobe_r[3];
  assign inp    = strobe_r[4];
  assign outp   = strobe_r[5];
  assign jump   = strobe_r[6];
  assign jumpz  = strobe_r[7];
  assign jumpnz = strobe_r[8];
  assign jumpc  = strobe_r[9];
  assign jumpnc = strobe_r[10];

endmodule

// File: tb/tb_ins_dec.sv
// Directed, table-driven bench for the instruction decoder.
module tb_ins_dec;

  logic       clk = 1'b0;
  logic       rst, decode, execute;
  logic [7:0] ir;
  logic load, add, sub, bitand, inp, outp, jump, jumpz, jumpnz, jumpc, jumpnc;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] S_NONE   = 11'd0;
  localparam logic [10:0] S_LOAD   = 11'd1;
  localparam logic [10:0] S_ADD    = 11'd2;
  localparam logic [10:0] S_SUB    = 11'd4;
  localparam logic [10:0] S_AND    = 11'd8;
  localparam logic [10:0] S_INP    = 11'd16;
  localparam logic [10:0] S_OUTP   = 11'd32;
  localparam logic [10:0] S_JUMP   = 11'd64;
  localparam logic [10:0] S_JUMPZ  = 11'd128;
  localparam logic [10:0] S_JUMPNZ = 11'd256;
  localparam logic [10:0] S_JUMPC  = 11'd512;
  localparam logic [10:0] S_JUMPNC = 11'd1024;

  typedef struct {
    logic [7:0]  ir;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [16];

  ins_dec dut (
    .clk(clk), .rst(rst), .ir(ir), .decode(decode), .execute(execute),
    .load(load), .add(add), .sub(sub), .bitand(bitand), .inp(inp),
    .outp(outp), .jump(jump), .jumpz(jumpz), .jumpnz(jumpnz),
    .jumpc(jumpc), .jumpnc(jumpnc)
  );

  assign outs = {jumpnc, jumpc, jumpnz, jumpz, jump, outp, inp, bitand, sub, add, load};

  always #5 clk = ~clk;

  // Independent reference: field-by-field opcode map
  function automatic logic [10:0] ref_dec(input logic [7:0] b);
    logic [3:0] major;
    major = b[7:4];
    if (major == 4'd0) return S_LOAD;
    if (major == 4'd1) return S_ADD;
    if (major == 4'd2) return S_SUB;
    if (major == 4'd3) return S_AND;
    if (major == 4'd4) return S_INP;
    if (major == 4'd5) return S_OUTP;
    if (major == 4'd8) return S_JUMP;
    if (major == 4'd9) begin
      if (b[3:2] == 2'd0) return S_JUMPZ;
      if (b[3:2] == 2'd1) return S_JUMPNZ;
      if (b[3:2] == 2'd2) return S_JUMPC;
      return S_JUMPNC;
    end
    return S_NONE;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] exp);
    checks++;
    if (outs !== exp || $countones(outs) > 1) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic e, input logic [7:0] v);
    rst = r; decode = d; execute = e; ir = v;
  endtask

  initial begin
    vecs[0]  = '{8'h00, S_LOAD};   vecs[1]  = '{8'h1F, S_ADD};
    vecs[2]  = '{8'h2A, S_SUB};    vecs[3]  = '{8'h35, S_AND};
    vecs[4]  = '{8'h4C, S_INP};    vecs[5]  = '{8'h5F, S_OUTP};
    vecs[6]  = '{8'h87, S_JUMP};   vecs[7]  = '{8'h93, S_JUMPZ};
    vecs[8]  = '{8'h96, S_JUMPNZ}; vecs[9]  = '{8'h9A, S_JUMPC};
    vecs[10] = '{8'h9D, S_JUMPNC}; vecs[11] = '{8'h60, S_NONE};
    vecs[12] = '{8'h7F, S_NONE};   vecs[13] = '{8'hA5, S_NONE};
    vecs[14] = '{8'hE0, S_NONE};   vecs[15] = '{8'hFF, S_NONE};

    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step(); step();
    check("reset_state", S_NONE);

    // Execute with no prior decode: captured value is the NOP reset opcode
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    step();
    check("exec_after_reset", S_NONE);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, vecs[i].ir);
      step();
      check($sformatf("vec%0d_decode", i), S_NONE);
      drive(1'b0, 1'b0, 1'b1, 8'hFF);
      step();
      check($sformatf("vec%0d_exec_%02h", i, vecs[i].ir), vecs[i].exp);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      step();
      check($sformatf("vec%0d_idle", i), S_NONE);
    end

    // jumpnz then jumpnc: exactly one-cycle strobe
    drive(1'b0, 1'b1, 1'b0, 8'b1001_0110);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check("jumpnz_strobe", S_JUMPNZ);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("jumpnz_one_cycle", S_NONE);
    drive(1'b0, 1'b1, 1'b0, 8'b1001_1101);
    step();
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check("jumpnc_strobe", S_JUMPNC);

    // Decode and execute together: bypass the new instruction
    drive(1'b0, 1'b1, 1'b1, 8'h98);
    step();
    check("bypass_jumpc", S_JUMPC);

    // Execute held: strobe stays asserted, op_q holds
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    check("held_exec_1", S_JUMPC);
    step();
    check("held_exec_2", S_JUMPC);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("held_exec_release", S_NONE);

    // Reset mid-execute of an add
    drive(1'b0, 1'b1, 1'b0, 8'h10);
    step();
    drive(1'b1, 1'b0, 1'b1, 8'h10);
    step();
    check("rst_mid_exec", S_NONE);
    drive(1'b0, 1'b0, 1'b0, 8'h10);
    step();
    check("rst_no_late_strobe", S_NONE);
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    step();
    check("rst_cleared_opq", S_NONE);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();

    // Full sweep of all instruction values
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(i));
      step();
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      step();
      check($sformatf("sweep_%02h", i), ref_dec(8'(i)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
